// File: rtl/cpu_defs.sv
// Shared encodings for the control unit: instruction opcodes, ALU op
// codes, step-state encoding and the control-strobe bundle.
package cpu_defs;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = OP_ADD;
    localparam logic [4:0] ALU_AND  = OP_AND;
    localparam logic [4:0] ALU_OR   = OP_OR;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT,
        S_PAUSED
    } state_t;

    typedef struct packed {
        logic read, write, mdr_in, mar_in;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic pc_in, pc_out, inc_pc, ir_in, y_in, z_in;
        logic hi_in, lo_in, conn_in;
        logic hi_out, lo_out, zhigh_out, zlow_out;
        logic mdr_out, c_out, inport_out, outport_in;
    } ctrl_t;

    // Immediate forms reuse the register-form ALU operation.
    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        unique case (op)
            OP_ADDI: imm_alu = ALU_ADD;
            OP_ANDI: imm_alu = ALU_AND;
            default: imm_alu = ALU_OR;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Moore step sequencer for the multi-cycle CPU datapath.
// CONTROL_UNIT_RUN_STOP_EN adds a stop input and a PAUSED state.
module control_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        clr,
`ifdef CONTROL_UNIT_RUN_STOP_EN
    input  logic        stop,
`endif
    input  logic [31:0] IRdata,
    input  logic        CON,
    output logic        read,
    output logic        write,
    output logic        MDRin,
    output logic        MARin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCin,
    output logic        PCout,
    output logic        incPC,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONN_in,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHighOut,
    output logic        ZLowOut,
    output logic        MDRout,
    output logic        Cout,
    output logic        InPortout,
    output logic        OutPortIn,
    output logic [4:0]  opcode,
    output logic        run
);

    state_t      state_q, state_d, back;
    ctrl_t       ctrl;
    logic [4:0]  ir_op, alu_op;
    logic        run_o, stop_req, unused_ir;
    logic        is_alu, is_imm, is_ld, is_ldi, is_st, is_mem;
    logic        is_md, is_nn, is_br, is_jr, is_jal, is_halt;
    logic        is_in, is_out, is_mfhi, is_mflo;

    assign ir_op     = IRdata[31:27];
    assign unused_ir = ^IRdata[26:0];

`ifdef CONTROL_UNIT_RUN_STOP_EN
    assign stop_req = stop;
`else
    assign stop_req = 1'b0;
`endif

    assign is_alu  = (ir_op >= OP_ADD) && (ir_op <= OP_ROL);
    assign is_imm  = (ir_op >= OP_ADDI) && (ir_op <= OP_ORI);
    assign is_ld   = (ir_op == OP_LD);
    assign is_ldi  = (ir_op == OP_LDI);
    assign is_st   = (ir_op == OP_ST);
    assign is_mem  = is_ld | is_ldi | is_st;
    assign is_md   = (ir_op == OP_MUL) || (ir_op == OP_DIV);
    assign is_nn   = (ir_op == OP_NEG) || (ir_op == OP_NOT);
    assign is_br   = (ir_op == OP_BR);
    assign is_jr   = (ir_op == OP_JR);
    assign is_jal  = (ir_op == OP_JAL);
    assign is_in   = (ir_op == OP_IN);
    assign is_out  = (ir_op == OP_OUT);
    assign is_mfhi = (ir_op == OP_MFHI);
    assign is_mflo = (ir_op == OP_MFLO);
    assign is_halt = (ir_op == OP_HALT);

    always_ff @(posedge clk) begin
        if (!clr) state_q <= S_RST;
        else      state_q <= state_d;
    end

    // Every "return to T0" may be diverted into PAUSED by stop.
    assign back = stop_req ? S_PAUSED : S_T0;

    always_comb begin
        state_d = S_RST;
        unique case (state_q)
            S_RST: state_d = back;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3: begin
                unique case (1'b1)
                    is_halt: state_d = S_HALT;
                    is_alu, is_imm, is_mem,
                    is_md, is_nn, is_br, is_jal:
                        state_d = S_T4;
                    default: state_d = back;
                endcase
            end
            S_T4: begin
                unique case (1'b1)
                    is_alu, is_imm, is_mem, is_md, is_br:
                        state_d = S_T5;
                    default: state_d = back;
                endcase
            end
            S_T5: begin
                unique case (1'b1)
                    is_ld, is_st, is_md, is_br:
                        state_d = S_T6;
                    default: state_d = back;
                endcase
            end
            S_T6: begin
                unique case (1'b1)
                    is_ld, is_st: state_d = S_T7;
                    default:      state_d = back;
                endcase
            end
            S_T7:     state_d = back;
            S_HALT:   state_d = S_HALT;
            S_PAUSED: state_d = stop_req ? S_PAUSED : S_T0;
            default:  state_d = S_RST;
        endcase
    end

    always_comb begin
        ctrl   = '0;
        alu_op = ALU_NONE;
        run_o  = 1'b1;
        unique case (state_q)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
            end
            S_T1: begin
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                unique case (1'b1)
                    is_alu, is_imm: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    is_mem: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    is_md: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    is_nn: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.z_in  = 1'b1;
                        alu_op     = ir_op;
                    end
                    is_br: begin
                        ctrl.gra     = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.conn_in = 1'b1;
                    end
                    is_jr: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.pc_in = 1'b1;
                    end
                    is_jal: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.grb    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    is_in: begin
                        ctrl.inport_out = 1'b1;
                        ctrl.gra        = 1'b1;
                        ctrl.r_in       = 1'b1;
                    end
                    is_out: begin
                        ctrl.gra        = 1'b1;
                        ctrl.r_out      = 1'b1;
                        ctrl.outport_in = 1'b1;
                    end
                    is_mfhi: begin
                        ctrl.hi_out = 1'b1;
                        ctrl.gra    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    is_mflo: begin
                        ctrl.lo_out = 1'b1;
                        ctrl.gra    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (1'b1)
                    is_alu: begin
                        ctrl.grc   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.z_in  = 1'b1;
                        alu_op     = ir_op;
                    end
                    is_imm: begin
                        ctrl.c_out = 1'b1;
                        ctrl.z_in  = 1'b1;
                        alu_op     = imm_alu(ir_op);
                    end
                    is_mem: begin
                        ctrl.c_out = 1'b1;
                        ctrl.z_in  = 1'b1;
                        alu_op     = ALU_ADD;
                    end
                    is_md: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.z_in  = 1'b1;
                        alu_op     = ir_op;
                    end
                    is_nn: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    is_br: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    is_jal: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (1'b1)
                    is_alu, is_imm, is_ldi: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    is_ld, is_st: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                    end
                    is_md: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.lo_in    = 1'b1;
                    end
                    is_br: begin
                        ctrl.c_out = 1'b1;
                        ctrl.z_in  = 1'b1;
                        alu_op     = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                unique case (1'b1)
                    is_ld: begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    is_st: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    is_md: begin
                        ctrl.zhigh_out = 1'b1;
                        ctrl.hi_in     = 1'b1;
                    end
                    // Branch target only reaches PC when the condition held.
                    is_br: begin
                        ctrl.zlow_out = CON;
                        ctrl.pc_in    = CON;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                unique case (1'b1)
                    is_ld: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    is_st: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.write   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT, S_PAUSED: run_o = 1'b0;
            default: ;
        endcase
    end

    assign read      = ctrl.read;
    assign write     = ctrl.write;
    assign MDRin     = ctrl.mdr_in;
    assign MARin     = ctrl.mar_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign PCin      = ctrl.pc_in;
    assign PCout     = ctrl.pc_out;
    assign incPC     = ctrl.inc_pc;
    assign IRin      = ctrl.ir_in;
    assign Yin       = ctrl.y_in;
    assign Zin       = ctrl.z_in;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign CONN_in   = ctrl.conn_in;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign ZHighOut  = ctrl.zhigh_out;
    assign ZLowOut   = ctrl.zlow_out;
    assign MDRout    = ctrl.mdr_out;
    assign Cout      = ctrl.c_out;
    assign InPortout = ctrl.inport_out;
    assign OutPortIn = ctrl.outport_in;
    assign opcode    = alu_op;
    assign run       = run_o;

endmodule
